// File: rtl/mcp_expander_scan_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mcp_expander_scan_if : candidate-driver bus bundle for the expander scanner
// rev 1.0
// ----------------------------------------------------------------------------
interface mcp_expander_scan_if #(
  parameter int NUM_DEV = 2,
  parameter int DATA_W  = 16
);
  localparam int SEL_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  logic [NUM_DEV-1:0]        dev_present;
  logic [NUM_DEV*DATA_W-1:0] dev_in;
  logic [NUM_DEV-1:0]        dev_scl_oe;
  logic [NUM_DEV-1:0]        dev_sda_oe;
  logic                      rescan;
  logic                      scl_oe;
  logic                      sda_oe;
  logic [SEL_W-1:0]          sel;
  logic                      sel_valid;
  logic [DATA_W-1:0]         data_out;
  logic [NUM_DEV-1:0]        found;
  logic                      change;

  modport master (
    output dev_present, dev_in, dev_scl_oe, dev_sda_oe, rescan,
    input  scl_oe, sda_oe, sel, sel_valid, data_out, found, change
  );

  modport slave (
    input  dev_present, dev_in, dev_scl_oe, dev_sda_oe, rescan,
    output scl_oe, sda_oe, sel, sel_valid, data_out, found, change
  );
endinterface
`default_nettype wire

// File: rtl/mcp_expander_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mcp_expander_scan : time-slotted detection of one I2C GPIO expander driver,
//                     then lock onto it and forward its bus and data
// rev 1.0
// ----------------------------------------------------------------------------
module mcp_expander_scan #(
  parameter int NUM_DEV     = 2,
  parameter int DATA_W      = 16,
  parameter int SLOT_CYCLES = 65536,
  parameter int LOSS_CYCLES = 1024
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  mcp_expander_scan_if.slave  bus
);
  localparam int SEL_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int T_W   = $clog2(SLOT_CYCLES);
  localparam int L_W   = $clog2(LOSS_CYCLES);
  localparam logic [T_W-1:0]   T_LAST = T_W'(SLOT_CYCLES - 1);
  localparam logic [L_W-1:0]   L_LAST = L_W'(LOSS_CYCLES - 1);
  localparam logic [SEL_W-1:0] S_LAST = SEL_W'(NUM_DEV - 1);

  typedef enum logic [0:0] {
    DETECT = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             r_state, w_state;
  logic [SEL_W-1:0]   r_s, w_s;
  logic [SEL_W-1:0]   r_sel, w_sel;
  logic [SEL_W-1:0]   w_owner, w_hi;
  logic [T_W-1:0]     r_t, w_t;
  logic [L_W-1:0]     r_loss, w_loss;
  logic [NUM_DEV-1:0] r_mask, w_mask;
  logic [NUM_DEV-1:0] r_found, w_found;
  logic               r_sel_valid, w_sel_valid;
  logic [DATA_W-1:0]  r_data, w_dev_word;
  logic               r_change;
  logic               w_pres_s, w_pres_sel;
  logic               w_scl, w_sda;

  // Reset forces device 0 onto the bus so the lines never float undefined.
  always_comb begin
    w_owner = '0;
    if (reset_n) w_owner = (r_state == LOCKED) ? r_sel : r_s;
  end

  always_comb begin
    w_scl = 1'b0;
    w_sda = 1'b0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (SEL_W'(k) == w_owner) begin
        w_scl = bus.dev_scl_oe[k];
        w_sda = bus.dev_sda_oe[k];
      end
    end
  end

  always_comb begin
    w_pres_s   = 1'b0;
    w_pres_sel = 1'b0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (SEL_W'(k) == r_s)   w_pres_s   = bus.dev_present[k];
      if (SEL_W'(k) == r_sel) w_pres_sel = bus.dev_present[k];
    end
  end

  always_comb begin
    w_dev_word = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (SEL_W'(k) == w_sel) w_dev_word = bus.dev_in[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state     = r_state;
    w_s         = r_s;
    w_t         = r_t;
    w_loss      = '0;
    w_mask      = r_mask;
    w_found     = r_found;
    w_sel       = r_sel;
    w_sel_valid = r_sel_valid;
    w_hi        = r_sel;
    case (r_state)
      DETECT: begin
        w_sel_valid = 1'b0;
        if (bus.rescan) begin
          w_s    = '0;
          w_t    = '0;
          w_mask = '0;
        end else if (r_t == T_LAST) begin
          w_t         = '0;
          w_mask[r_s] = w_pres_s;
          if (r_s == S_LAST) begin
            w_found = w_mask;
            w_s     = '0;
            // Ascending scan: the last hit is the highest-index device.
            for (int k = 0; k < NUM_DEV; k++) begin
              if (w_mask[k]) w_hi = SEL_W'(k);
            end
            if (|w_mask) begin
              w_state     = LOCKED;
              w_sel       = w_hi;
              w_sel_valid = 1'b1;
            end
            w_mask = '0;
          end else begin
            w_s = r_s + SEL_W'(1);
          end
        end else begin
          w_t = r_t + T_W'(1);
        end
      end
      LOCKED: begin
        if (!w_pres_sel) w_loss = r_loss + L_W'(1);
        if (bus.rescan || (!w_pres_sel && (r_loss == L_LAST))) begin
          w_state     = DETECT;
          w_s         = '0;
          w_t         = '0;
          w_loss      = '0;
          w_mask      = '0;
          w_sel_valid = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= DETECT;
      r_s         <= '0;
      r_t         <= '0;
      r_loss      <= '0;
      r_mask      <= '0;
      r_found     <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_data      <= '0;
      r_change    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_s         <= w_s;
      r_t         <= w_t;
      r_loss      <= w_loss;
      r_mask      <= w_mask;
      r_found     <= w_found;
      r_sel       <= w_sel;
      r_sel_valid <= w_sel_valid;
      r_data      <= (w_state == LOCKED) ? w_dev_word : '0;
      r_change    <= (w_sel_valid != r_sel_valid);
    end
  end

  assign bus.scl_oe    = w_scl;
  assign bus.sda_oe    = w_sda;
  assign bus.sel       = r_sel;
  assign bus.sel_valid = r_sel_valid;
  assign bus.data_out  = r_data;
  assign bus.found     = r_found;
  assign bus.change    = r_change;
endmodule
`default_nettype wire

// File: tb/tb_mcp_expander_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mcp_expander_scan : directed bench with a slot-timeline reference model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_mcp_expander_scan;
  localparam int NUM_DEV = 2;
  localparam int DATA_W  = 16;
  localparam int SLOT    = 16;
  localparam int LOSS    = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mcp_expander_scan_if #(.NUM_DEV(NUM_DEV), .DATA_W(DATA_W)) bus_if ();

  mcp_expander_scan #(
    .NUM_DEV(NUM_DEV), .DATA_W(DATA_W), .SLOT_CYCLES(SLOT), .LOSS_CYCLES(LOSS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if.slave)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_chg = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: scan position is cycles since scan start; slot = pos / SLOT.
  bit                 m_locked;
  int                 m_pos, m_absent, m_sel, mp_slot;
  bit [NUM_DEV-1:0]   m_mask, m_found;
  bit                 m_valid, m_change, mp_prev;
  bit [DATA_W-1:0]    m_data;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_locked = 0; m_pos = 0; m_absent = 0; m_mask = '0; m_found = '0;
      m_sel = 0; m_valid = 0; m_change = 0; m_data = '0;
    end else begin
      mp_prev = m_valid;
      if (!m_locked) begin
        if (bus_if.rescan) begin
          m_pos = 0; m_mask = '0;
        end else if (m_pos % SLOT == SLOT - 1) begin
          mp_slot = m_pos / SLOT;
          m_mask[mp_slot] = bus_if.dev_present[mp_slot];
          if (mp_slot == NUM_DEV - 1) begin
            m_found = m_mask;
            m_pos = 0;
            if (m_mask != 0) begin
              m_locked = 1; m_absent = 0;
              for (int k = 0; k < NUM_DEV; k++) if (m_mask[k]) m_sel = k;
            end
            m_mask = '0;
          end else m_pos++;
        end else m_pos++;
      end else begin
        m_absent = bus_if.dev_present[m_sel] ? 0 : m_absent + 1;
        if (bus_if.rescan || m_absent == LOSS) begin
          m_locked = 0; m_pos = 0; m_absent = 0;
        end
      end
      m_valid  = m_locked;
      m_change = (m_valid != mp_prev);
      m_data   = m_locked ? bus_if.dev_in[m_sel*DATA_W +: DATA_W] : '0;
    end
  end

  always @(negedge clk) begin
    int owner;
    if (cmp_en) begin
      owner = !reset_n ? 0 : (m_locked ? m_sel : m_pos / SLOT);
      chk("scl_oe",    32'(bus_if.scl_oe),    32'(bus_if.dev_scl_oe[owner]));
      chk("sda_oe",    32'(bus_if.sda_oe),    32'(bus_if.dev_sda_oe[owner]));
      chk("sel",       32'(bus_if.sel),       32'(m_sel));
      chk("sel_valid", 32'(bus_if.sel_valid), 32'(m_valid));
      chk("data_out",  32'(bus_if.data_out),  32'(m_data));
      chk("found",     32'(bus_if.found),     32'(m_found));
      chk("change",    32'(bus_if.change),    32'(m_change));
      if (bus_if.change === 1'b1) n_chg++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus_if.dev_present = '0;
    bus_if.dev_in      = '0;
    bus_if.dev_scl_oe  = '0;
    bus_if.dev_sda_oe  = '0;
    bus_if.rescan      = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    chk("rst_sel_valid", 32'(bus_if.sel_valid), 0);
    chk("rst_found", 32'(bus_if.found), 0);
    chk("rst_data", 32'(bus_if.data_out), 0);

    // Both devices present: lock on device 1 after two slots.
    bus_if.dev_present = 2'b11;
    bus_if.dev_in      = {16'h1111, 16'h2222};
    reset_n = 1'b1;
    base = n_chg;
    tick(31);
    chk("both_pre_lock_valid", 32'(bus_if.sel_valid), 0);
    tick(1);
    chk("both_found", 32'(bus_if.found), 32'h3);
    chk("both_sel", 32'(bus_if.sel), 1);
    chk("both_valid", 32'(bus_if.sel_valid), 1);
    chk("both_data", 32'(bus_if.data_out), 32'h1111);
    tick(5);
    chk("both_change_count", 32'(n_chg - base), 1);

    // Data forwarding and rescan.
    bus_if.dev_in = {16'hA55A, 16'h2222};
    tick(1);
    chk("fwd_data", 32'(bus_if.data_out), 32'hA55A);
    bus_if.rescan = 1'b1;
    tick(1);
    bus_if.rescan = 1'b0;
    chk("rescan_data", 32'(bus_if.data_out), 0);
    chk("rescan_valid", 32'(bus_if.sel_valid), 0);
    chk("rescan_change", 32'(bus_if.change), 1);
    tick(32);
    chk("relock_valid", 32'(bus_if.sel_valid), 1);

    // Loss filter: 7 absent cycles tolerated, 8 drop the lock.
    bus_if.dev_present = 2'b01;
    tick(7);
    bus_if.dev_present = 2'b11;
    tick(1);
    chk("loss7_valid", 32'(bus_if.sel_valid), 1);
    bus_if.dev_present = 2'b01;
    tick(7);
    chk("loss8_pre_valid", 32'(bus_if.sel_valid), 1);
    tick(1);
    chk("loss8_valid", 32'(bus_if.sel_valid), 0);
    chk("loss8_change", 32'(bus_if.change), 1);

    // Only device 0 present; during slot 1 the bus follows device 1.
    tick(20);
    bus_if.dev_scl_oe = 2'b10;
    bus_if.dev_sda_oe = 2'b01;
    #1;
    chk("slot1_scl", 32'(bus_if.scl_oe), 1);
    chk("slot1_sda", 32'(bus_if.sda_oe), 0);
    bus_if.dev_scl_oe = 2'b01;
    #1;
    chk("slot1_scl_ignore0", 32'(bus_if.scl_oe), 0);
    tick(12);
    chk("dev0_sel", 32'(bus_if.sel), 0);
    chk("dev0_valid", 32'(bus_if.sel_valid), 1);
    chk("dev0_found", 32'(bus_if.found), 32'h1);
    chk("dev0_scl", 32'(bus_if.scl_oe), 1);

    // Neither present: repeated empty scans, no pulses.
    bus_if.dev_present = 2'b00;
    tick(8);
    chk("none_lost", 32'(bus_if.sel_valid), 0);
    tick(1);
    base = n_chg;
    tick(70);
    chk("none_found", 32'(bus_if.found), 0);
    chk("none_valid", 32'(bus_if.sel_valid), 0);
    chk("none_data", 32'(bus_if.data_out), 0);
    chk("none_change_count", 32'(n_chg - base), 0);

    // Reset mid-slot 1, then while locked.
    bus_if.dev_present = 2'b11;
    bus_if.rescan = 1'b1;
    tick(1);
    bus_if.rescan = 1'b0;
    tick(20);
    reset_n = 1'b0;
    bus_if.dev_scl_oe = 2'b01;
    #1;
    chk("rst_owner_scl", 32'(bus_if.scl_oe), 1);
    tick(1);
    chk("rst_mid_valid", 32'(bus_if.sel_valid), 0);
    chk("rst_mid_sel", 32'(bus_if.sel), 0);
    reset_n = 1'b1;
    tick(31);
    chk("rst_restart_prelock", 32'(bus_if.sel_valid), 0);
    tick(1);
    chk("rst_restart_lock", 32'(bus_if.sel_valid), 1);
    chk("rst_restart_sel", 32'(bus_if.sel), 1);
    reset_n = 1'b0;
    tick(1);
    chk("rst_lock_valid", 32'(bus_if.sel_valid), 0);
    chk("rst_lock_sel", 32'(bus_if.sel), 0);
    chk("rst_lock_found", 32'(bus_if.found), 0);
    chk("rst_lock_data", 32'(bus_if.data_out), 0);
    chk("rst_lock_change", 32'(bus_if.change), 0);
    reset_n = 1'b1;
    tick(32);
    chk("rst_lock_relock", 32'(bus_if.sel_valid), 1);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mcp_expander_scan.md
MCP_EXPANDER_SCAN -- requirements
Module: mcp_expander_scan

Interface
REQ-001 SHALL have parameter NUM_DEV, default 2, number of candidate expander drivers sharing one I2C bus.
REQ-002 SHALL have parameter DATA_W, default 16, GPIO input word width per device.
REQ-003 SHALL have parameter SLOT_CYCLES, default 65536, detect slot length in clocks (>=4).
REQ-004 SHALL have parameter LOSS_CYCLES, default 1024, consecutive absent clocks declaring loss (>=2).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port dev_present  input  NUM_DEV  per-driver "chip acknowledged" flag.
REQ-008 SHALL have port dev_in  input  NUM_DEV*DATA_W  per-driver GPIO word, device k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port dev_scl_oe  input  NUM_DEV  per-driver SCL pull-low request.
REQ-010 SHALL have port dev_sda_oe  input  NUM_DEV  per-driver SDA pull-low request.
REQ-011 SHALL have port rescan  input  1  single-cycle request to restart detection.
REQ-012 SHALL have port scl_oe  output  1  bus SCL pull-low enable (open-drain).
REQ-013 SHALL have port sda_oe  output  1  bus SDA pull-low enable (open-drain).
REQ-014 SHALL have port sel  output  max(1,$clog2(NUM_DEV))  index of locked device.
REQ-015 SHALL have port sel_valid  output  1  a device is locked.
REQ-016 SHALL have port data_out  output  DATA_W  GPIO word of locked device.
REQ-017 SHALL have port found  output  NUM_DEV  devices that acknowledged in the last completed scan.
REQ-018 SHALL have port change  output  1  one-cycle pulse on lock, loss, or selection change.

Function
REQ-019 SHALL implement states DETECT, LOCKED; DETECT holds slot counter s (0..NUM_DEV-1) and slot timer t.
REQ-020 In DETECT, bus owner SHALL be s; in LOCKED, owner SHALL be sel; scl_oe/sda_oe SHALL equal dev_scl_oe/dev_sda_oe[owner] combinationally (zero latency); non-owners ignored.
REQ-021 In DETECT, t SHALL increment each clock; at t==SLOT_CYCLES-1, dev_present[s] SHALL be captured into a scan mask bit s, t SHALL clear, s SHALL advance.
REQ-022 At end of slot NUM_DEV-1, found SHALL load the complete scan mask in the same edge.
REQ-023 At scan end with nonzero mask: go LOCKED, sel = highest-index found device, sel_valid=1.
REQ-024 At scan end with zero mask: stay DETECT, restart at s=0, sel_valid=0, sel unchanged.
REQ-025 In LOCKED, loss counter SHALL count consecutive cycles with dev_present[sel]==0 and clear on any cycle it is 1.
REQ-026 Loss counter reaching LOSS_CYCLES-1 while absent SHALL enter DETECT at s=0,t=0 and clear sel_valid on that edge.
REQ-027 rescan=1 in LOCKED SHALL enter DETECT at s=0,t=0 next edge, clear sel_valid; rescan in DETECT SHALL restart scan at s=0,t=0.
REQ-028 rescan and loss in same cycle SHALL act as one restart with a single change pulse.
REQ-029 data_out SHALL register dev_in[sel] each clock while LOCKED (1-cycle latency), and SHALL be 0 in every clock of DETECT.
REQ-030 change SHALL pulse one cycle on the edge sel_valid 0->1, on sel_valid 1->0, and never otherwise.
REQ-031 Counters SHALL be sized to hold SLOT_CYCLES-1 and LOSS_CYCLES-1 exactly; no wrap in normal operation.

Reset
REQ-032 reset_n=0 at a clock edge SHALL set state DETECT, s=0, t=0, loss counter 0, scan mask 0, found=0, sel=0, sel_valid=0, data_out=0, change=0, regardless of state, including mid-slot or while LOCKED.
REQ-033 During reset, owner SHALL be 0 so scl_oe/sda_oe follow device 0.

Verification
REQ-034 NUM_DEV=2, SLOT_CYCLES=16: both present -> after 32 clocks found=2'b11, sel=1, sel_valid=1, change pulse once.
REQ-035 Only device 0 present -> sel=0, sel_valid=1 at clock 32; during clocks 16-31 scl_oe tracks dev_scl_oe[1] only.
REQ-036 Neither present -> found=0, sel_valid stays 0, scan repeats every 32 clocks, data_out=0, no change pulse.
REQ-037 Locked on 1, LOSS_CYCLES=8: drop dev_present[1] 7 clocks then restore -> stays locked; drop 8 clocks -> sel_valid 0, change pulse, rescan starts.
REQ-038 Locked, dev_in[1]=16'hA55A -> data_out=16'hA55A one clock later; rescan pulse -> data_out=0, sel_valid=0 next edge.
REQ-039 Assert reset_n=0 mid-slot 1 and while LOCKED -> all outputs at REQ-032 values next edge, scan restarts at slot 0.
